// File: rtl/cpu_pkg.sv
// Shared control-flow types and constants for the program-counter stage.
package cpu_pkg;

  typedef enum logic [1:0] {
    BRANCH   = 2'd0,
    JAL      = 2'd1,
    JALR     = 2'd2,
    RESERVED = 2'd3
  } ctrl_kind_e;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RESOLVE = 2'd1,
    TRAP    = 2'd2
  } pc_state_e;

  localparam int unsigned INSTR_BYTES = 32'd4;

  function automatic logic word_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational target, taken and misalignment evaluation for one latched
// control-flow instruction.
module branch_target_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  ctrl_kind_e              kind,
  input  logic [ADDR_WIDTH-1:0]   instr_pc,
  input  logic [DATA_WIDTH-1:0]   imm,
  input  logic [DATA_WIDTH-1:0]   rs1_value,
  input  logic                    branch_condition,
  output logic [ADDR_WIDTH-1:0]   target,
  output logic                    taken,
  output logic                    misaligned
);

  localparam logic [ADDR_WIDTH-1:0] CLR_LSB = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  logic [ADDR_WIDTH-1:0] imm_ext_s;
  logic [ADDR_WIDTH-1:0] rs1_ext_s;
  logic [ADDR_WIDTH-1:0] pc_rel_s;
  logic [ADDR_WIDTH-1:0] reg_rel_s;

  // The immediate is sign-extended; rs1 is treated as a plain address.
  assign imm_ext_s = ADDR_WIDTH'($signed(imm));
  assign rs1_ext_s = ADDR_WIDTH'(rs1_value);
  assign pc_rel_s  = instr_pc + imm_ext_s;
  assign reg_rel_s = (rs1_ext_s + imm_ext_s) & CLR_LSB;

  // Select target and taken by instruction kind.
  always_comb begin
    target = {ADDR_WIDTH{1'b0}};
    taken  = 1'b0;
    case (kind)
      BRANCH: begin
        target = pc_rel_s;
        taken  = branch_condition;
      end
      JAL: begin
        target = pc_rel_s;
        taken  = 1'b1;
      end
      JALR: begin
        target = reg_rel_s;
        taken  = 1'b1;
      end
      default: begin
        target = pc_rel_s;
        taken  = 1'b0;
      end
    endcase
    misaligned = taken && word_misaligned(target[1:0]);
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Program-counter stage: sequential fetch, BRANCH/JAL/JALR resolution with flush,
// link write-back and misaligned-target trap. Optional counters: BRANCH_PC_UNIT_PERF_EN.
module branch_pc_unit
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] TRAP_PC    = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  pc_valid,
  input  logic                  pc_ready,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [1:0]            instr_kind,
  input  logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] rs1_value,
  input  logic                  rs1_valid,
  input  logic                  branch_condition,
  input  logic                  branch_valid,
  output logic                  flush,
  output logic [DATA_WIDTH-1:0] link_value,
  output logic                  link_valid,
  output logic                  trap,
  input  logic                  trap_ack
`ifdef BRANCH_PC_UNIT_PERF_EN
  ,
  output logic [31:0]           perf_resolved,
  output logic [31:0]           perf_taken
`endif
);

  pc_state_e             state_r;
  ctrl_kind_e            kind_r;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] instr_pc_r;
  logic [DATA_WIDTH-1:0] imm_r;
  logic                  pc_valid_r;
  logic                  flush_r;
  logic                  link_valid_r;
  logic                  trap_r;

  logic [ADDR_WIDTH-1:0] target_s;
  logic [ADDR_WIDTH-1:0] seq_pc_s;
  logic                  taken_s;
  logic                  misaligned_s;
  logic                  resolve_ok_s;

  assign pc          = pc_r;
  assign pc_valid    = pc_valid_r;
  assign flush       = flush_r;
  assign link_valid  = link_valid_r;
  assign trap        = trap_r;
  assign instr_ready = pc_valid_r && (ctrl_kind_e'(instr_kind) != RESERVED);
  assign seq_pc_s    = instr_pc_r + ADDR_WIDTH'(INSTR_BYTES);
  assign link_value  = DATA_WIDTH'(seq_pc_s);

  branch_target_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_target (
    .kind             (kind_r),
    .instr_pc         (instr_pc_r),
    .imm              (imm_r),
    .rs1_value        (rs1_value),
    .branch_condition (branch_condition),
    .target           (target_s),
    .taken            (taken_s),
    .misaligned       (misaligned_s)
  );

  // Operand readiness needed before the latched instruction can resolve.
  always_comb begin
    resolve_ok_s = 1'b0;
    case (kind_r)
      BRANCH:  resolve_ok_s = branch_valid;
      JAL:     resolve_ok_s = 1'b1;
      JALR:    resolve_ok_s = rs1_valid;
      default: resolve_ok_s = 1'b0;
    endcase
  end

  // Control FSM; pc_valid is a register so it stays low while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= RUN;
      kind_r       <= BRANCH;
      pc_r         <= RESET_PC;
      instr_pc_r   <= {ADDR_WIDTH{1'b0}};
      imm_r        <= {DATA_WIDTH{1'b0}};
      pc_valid_r   <= 1'b0;
      flush_r      <= 1'b0;
      link_valid_r <= 1'b0;
      trap_r       <= 1'b0;
    end else begin
      flush_r      <= 1'b0;
      link_valid_r <= 1'b0;
      case (state_r)
        RUN: begin
          pc_valid_r <= 1'b1;
          if (instr_valid && instr_ready) begin
            kind_r     <= ctrl_kind_e'(instr_kind);
            instr_pc_r <= instr_pc;
            imm_r      <= imm;
            pc_valid_r <= 1'b0;
            state_r    <= RESOLVE;
          end else if (pc_valid_r && pc_ready) begin
            pc_r <= pc_r + ADDR_WIDTH'(INSTR_BYTES);
          end
        end
        RESOLVE: begin
          if (resolve_ok_s) begin
            flush_r <= 1'b1;
            if (misaligned_s) begin
              trap_r  <= 1'b1;
              state_r <= TRAP;
            end else begin
              pc_r         <= taken_s ? target_s : seq_pc_s;
              link_valid_r <= (kind_r == JAL) || (kind_r == JALR);
              pc_valid_r   <= 1'b1;
              state_r      <= RUN;
            end
          end
        end
        TRAP: begin
          if (trap_ack) begin
            trap_r     <= 1'b0;
            pc_r       <= TRAP_PC;
            pc_valid_r <= 1'b1;
            state_r    <= RUN;
          end
        end
        default: begin
          trap_r     <= 1'b0;
          pc_valid_r <= 1'b0;
          state_r    <= RUN;
        end
      endcase
    end
  end

`ifdef BRANCH_PC_UNIT_PERF_EN
  logic [31:0] perf_resolved_r;
  logic [31:0] perf_taken_r;

  assign perf_resolved = perf_resolved_r;
  assign perf_taken    = perf_taken_r;

  // Saturating counters of non-trapping resolutions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_resolved_r <= 32'd0;
      perf_taken_r    <= 32'd0;
    end else if (state_r == RESOLVE && resolve_ok_s && !misaligned_s) begin
      if (perf_resolved_r != 32'hFFFF_FFFF) begin
        perf_resolved_r <= perf_resolved_r + 32'd1;
      end
      if (taken_s && perf_taken_r != 32'hFFFF_FFFF) begin
        perf_taken_r <= perf_taken_r + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: cycle-level reference model checked on every
// falling edge, plus hand-computed literal expectations at key points.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  instr_kind;
  logic [31:0] instr_pc;
  logic [31:0] imm;
  logic [31:0] rs1_value;
  logic        rs1_valid;
  logic        branch_condition;
  logic        branch_valid;
  logic        flush;
  logic [31:0] link_value;
  logic        link_valid;
  logic        trap;
  logic        trap_ack;

  int checks = 0;
  int errors = 0;

  branch_pc_unit dut (
    .clk (clk), .rst_n (rst_n), .pc (pc), .pc_valid (pc_valid), .pc_ready (pc_ready),
    .instr_valid (instr_valid), .instr_ready (instr_ready), .instr_kind (instr_kind),
    .instr_pc (instr_pc), .imm (imm), .rs1_value (rs1_value), .rs1_valid (rs1_valid),
    .branch_condition (branch_condition), .branch_valid (branch_valid), .flush (flush),
    .link_value (link_value), .link_valid (link_valid), .trap (trap), .trap_ack (trap_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = fetching, 1 = waiting on operands, 2 = trapped.
  int          m_mode;
  logic        m_live, m_flush, m_link, m_trap;
  logic [31:0] m_pc, p_pc, p_imm, tgt;
  logic [1:0]  p_kind;
  logic        ready_now, tk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_live = 1'b0; m_flush = 1'b0; m_link = 1'b0; m_trap = 1'b0;
      m_pc = 32'h0;
    end else begin
      m_flush = 1'b0;
      m_link  = 1'b0;
      if (m_mode == 0) begin
        if (m_live && instr_valid && instr_kind != 2'd3) begin
          p_kind = instr_kind; p_pc = instr_pc; p_imm = imm;
          m_mode = 1; m_live = 1'b0;
        end else begin
          if (m_live && pc_ready) m_pc = m_pc + 32'd4;
          m_live = 1'b1;
        end
      end else if (m_mode == 1) begin
        ready_now = (p_kind == 2'd0) ? branch_valid : (p_kind == 2'd1) ? 1'b1 : rs1_valid;
        if (ready_now) begin
          tgt = (p_kind == 2'd2) ? ((rs1_value + p_imm) & 32'hFFFF_FFFE) : (p_pc + p_imm);
          tk  = (p_kind != 2'd0) || branch_condition;
          m_flush = 1'b1;
          if (tk && (tgt % 32'd4) != 32'd0) begin
            m_trap = 1'b1; m_mode = 2;
          end else begin
            m_pc = tk ? tgt : p_pc + 32'd4;
            m_link = (p_kind != 2'd0);
            m_live = 1'b1; m_mode = 0;
          end
        end
      end else begin
        if (trap_ack) begin
          m_pc = 32'h100; m_trap = 1'b0; m_live = 1'b1; m_mode = 0;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the rising edge.
  always @(negedge clk) begin
    check("pc", pc, m_pc);
    check("pc_valid", {31'd0, pc_valid}, {31'd0, m_live});
    check("instr_ready", {31'd0, instr_ready}, {31'd0, m_live && (instr_kind != 2'd3)});
    check("flush", {31'd0, flush}, {31'd0, m_flush});
    check("link_valid", {31'd0, link_valid}, {31'd0, m_link});
    check("trap", {31'd0, trap}, {31'd0, m_trap});
    if (m_link) check("link_value", link_value, p_pc + 32'd4);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] kind, input logic [31:0] ipc, input logic [31:0] im);
    instr_valid = 1'b1; instr_kind = kind; instr_pc = ipc; imm = im;
    tick(1);
    instr_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pc_ready = 1'b0; instr_valid = 1'b0; instr_kind = 2'd0;
    instr_pc = 32'h0; imm = 32'h0; rs1_value = 32'h0; rs1_valid = 1'b0;
    branch_condition = 1'b0; branch_valid = 1'b0; trap_ack = 1'b0;
    tick(3);
    check("lit_reset_pc", pc, 32'h0);
    check("lit_reset_pc_valid", {31'd0, pc_valid}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("lit_first_valid", {31'd0, pc_valid}, 32'd1);

    // Sequential fetch.
    pc_ready = 1'b1;
    tick(1); check("lit_seq4", pc, 32'h4);
    tick(1); check("lit_seq8", pc, 32'h8);
    tick(1); check("lit_seqC", pc, 32'hC);
    tick(2); check("lit_seq14", pc, 32'h14);

    // JAL accepted while fetch handshake is also offered.
    send(2'd1, 32'h10, 32'h100);
    check("lit_jal_hold", pc, 32'h14);
    pc_ready = 1'b0;
    tick(1);
    check("lit_jal_pc", pc, 32'h110);
    check("lit_jal_link", link_value, 32'h14);
    check("lit_jal_flush", {31'd0, flush}, 32'd1);
    tick(1);

    // Taken BRANCH with condition arriving late.
    send(2'd0, 32'h40, 32'h20);
    tick(2);
    check("lit_br_wait", {31'd0, pc_valid}, 32'd0);
    branch_valid = 1'b1; branch_condition = 1'b1;
    tick(1);
    check("lit_br_taken", pc, 32'h60);
    branch_valid = 1'b0;
    tick(1);

    // Not-taken BRANCH.
    branch_valid = 1'b1; branch_condition = 1'b0;
    send(2'd0, 32'h40, 32'h20);
    tick(1);
    check("lit_br_not", pc, 32'h44);
    branch_valid = 1'b0;

    // Reserved kind is refused; trap_ack outside TRAP is ignored.
    instr_valid = 1'b1; instr_kind = 2'd3; trap_ack = 1'b1;
    #1 check("lit_rsv_ready", {31'd0, instr_ready}, 32'd0);
    tick(2);
    instr_valid = 1'b0; trap_ack = 1'b0;
    check("lit_rsv_pc", pc, 32'h44);

    // JALR to a misaligned target traps, then recovers at TRAP_PC.
    rs1_valid = 1'b1; rs1_value = 32'h1003;
    send(2'd2, 32'h200, 32'h4);
    tick(1);
    check("lit_trap", {31'd0, trap}, 32'd1);
    check("lit_trap_pc", pc, 32'h44);
    tick(1);
    trap_ack = 1'b1;
    tick(1);
    trap_ack = 1'b0;
    check("lit_trap_ret", pc, 32'h100);

    // JALR waiting on rs1, bit0 cleared to an aligned target.
    rs1_valid = 1'b0; rs1_value = 32'h2001;
    send(2'd2, 32'h300, 32'h4);
    tick(2);
    rs1_valid = 1'b1;
    tick(1);
    check("lit_jalr_pc", pc, 32'h2004);
    check("lit_jalr_link", link_value, 32'h304);

    // JAL to the top of the address space, then fetch wraps to zero.
    send(2'd1, 32'h0, 32'hFFFF_FFFC);
    tick(1);
    check("lit_top", pc, 32'hFFFF_FFFC);
    pc_ready = 1'b1;
    tick(1);
    check("lit_wrap", pc, 32'h0);
    pc_ready = 1'b0;

    // Reset while waiting for branch_valid.
    send(2'd0, 32'h80, 32'h8);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("lit_rst_pc", pc, 32'h0);
    check("lit_rst_flush", {31'd0, flush}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    branch_valid = 1'b1; branch_condition = 1'b1;
    tick(3);
    check("lit_rst_run", pc, 32'h0);
    branch_valid = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
